// File: rtl/vw_frame_receiver.sv
// Virtual-wire host->FPGA frame receiver: synchronises toggle-handshaked words from the JTAG
// virtual_wire source, assembles them into one wide frame and offers it on a valid/ready stream.
module vw_frame_receiver #(
  parameter int WORD_WIDTH      = 32,
  parameter int WORDS_PER_FRAME = 8,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic [WORD_WIDTH+1:0]                 i_vw_source,
  output logic [CNT_WIDTH+2:0]                  o_vw_probe,
  output logic [WORD_WIDTH*WORDS_PER_FRAME-1:0] o_out_data,
  output logic                                  o_out_valid,
  input  logic                                  i_out_ready
);

  localparam int FRAME_WIDTH = WORD_WIDTH * WORDS_PER_FRAME;
  localparam int IDX_WIDTH   = $clog2(WORDS_PER_FRAME);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {PRIME, COLLECT, HOLD} state_t;

  state_t                 r_state;
  logic [WORD_WIDTH+1:0]  r_sync1;
  logic [WORD_WIDTH+1:0]  r_sync2;
  logic                   r_prev_req;
  logic [1:0]             r_prime_cnt;
  logic [IDX_WIDTH-1:0]   r_idx;
  logic                   r_ack_flip;
  logic                   r_ack;
  logic                   r_err;
  logic                   r_busy;
  logic [CNT_WIDTH-1:0]   r_frame_cnt;
  logic [FRAME_WIDTH-1:0] r_data;
  logic                   r_valid;

  logic                   w_req;
  logic                   w_last;
  logic                   w_edge;
  logic [WORD_WIDTH-1:0]  w_word;

  assign w_req  = r_sync2[WORD_WIDTH+1];
  assign w_last = r_sync2[WORD_WIDTH];
  assign w_word = r_sync2[WORD_WIDTH-1:0];
  assign w_edge = w_req ^ r_prev_req;

  // The ack flip is staged through r_ack_flip so it lands one edge after the word is taken.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_prev_req  <= 1'b0;
      r_state     <= PRIME;
      r_prime_cnt <= '0;
      r_idx       <= '0;
      r_ack_flip  <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_sync1    <= i_vw_source;
      r_sync2    <= r_sync1;
      r_prev_req <= w_req;
      r_ack_flip <= 1'b0;
      if (r_ack_flip) begin
        r_ack <= ~r_ack;
      end
      case (r_state)
        PRIME: begin
          // Adopting the synchronised toggle as ack hides a toggle the host left set across reset.
          if (r_prime_cnt == 2'd2) begin
            r_ack   <= w_req;
            r_busy  <= 1'b0;
            r_state <= COLLECT;
          end else begin
            r_prime_cnt <= r_prime_cnt + 2'd1;
            r_busy      <= 1'b1;
          end
        end
        COLLECT: begin
          if (w_edge) begin
            for (int i = 0; i < WORDS_PER_FRAME; i++) begin
              if (r_idx == IDX_WIDTH'(i)) begin
                r_data[FRAME_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH] <= w_word;
              end
            end
            if (w_last && (r_idx == LAST_IDX)) begin
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_idx   <= '0;
              r_state <= HOLD;
            end else if (!w_last && (r_idx != LAST_IDX)) begin
              r_idx      <= r_idx + IDX_WIDTH'(1);
              r_ack_flip <= 1'b1;
            end else begin
              r_err      <= 1'b1;
              r_idx      <= '0;
              r_ack_flip <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (r_valid && i_out_ready) begin
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
            r_ack_flip  <= 1'b1;
            r_state     <= COLLECT;
          end
        end
        default: r_state <= PRIME;
      endcase
    end
  end

  assign o_vw_probe  = {r_frame_cnt, r_busy, r_err, r_ack};
  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;

endmodule
